rf_write_scheduler: RTL

- Arbitrates the register file's single write port among three writeback sources: ALU, memory-load, and MULDIV.
- MULDIV (Type A funct 0100/0101) yields a 32-bit result: low half to Rd, high half to R15, on two consecutive port cycles.
- Sits between execute/memory stages and the 16x16 register file; drives its RegWrite/address/data inputs.

---
 rtl/rf_pkg.sv | 26 ++
 rtl/rr_arbiter3.sv | 51 +++++
 rtl/rf_write_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write scheduler.
package rf_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 4;
    localparam int RF_HI_REG = 15;

    localparam logic [1:0] REQ_ALU = 2'd0;
    localparam logic [1:0] REQ_MEM = 2'd1;
    localparam logic [1:0] REQ_MD  = 2'd2;

    localparam logic [3:0] OPC_TYPE_A   = 4'b1111;
    localparam logic [3:0] FUNCT_MULDIV0 = 4'b0100;
    localparam logic [3:0] FUNCT_MULDIV1 = 4'b0101;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_MD_HI = 1'b1
    } sched_state_e;

    // Successor in the 0 -> 1 -> 2 -> 0 requester rotation.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : (idx + 2'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter; the pointer records the last granted requester.
module rr_arbiter3
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic [2:0] req_i,
    output logic [2:0] gnt_o
);

    logic [1:0] ptr_q, ptr_d;
    logic [1:0] c0_s, c1_s, win_s;
    logic       any_s;
    logic [3:0] req_pad_s;

    // Pick the first requester after the last grant; a grant is always an accept.
    always_comb begin
        req_pad_s = {1'b0, req_i};
        c0_s      = rr_next(ptr_q);
        c1_s      = rr_next(c0_s);
        win_s     = ptr_q;
        any_s     = 1'b1;
        if (req_pad_s[c0_s]) begin
            win_s = c0_s;
        end else if (req_pad_s[c1_s]) begin
            win_s = c1_s;
        end else if (req_pad_s[ptr_q]) begin
            win_s = ptr_q;
        end else begin
            any_s = 1'b0;
        end
        if (en_i && any_s) begin
            gnt_o = 3'b001 << win_s;
            ptr_d = win_s;
        end else begin
            gnt_o = 3'b000;
            ptr_d = ptr_q;
        end
    end

    // Pointer starts on MULDIV so the ALU wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= REQ_MD;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Single-write-port scheduler for ALU, load and MULDIV writebacks.
// Optional stall statistic enabled by defining RF_SCHED_STATS_EN.
module rf_write_scheduler
    import rf_pkg::*;
#(
    parameter int DATA_W      = RF_DATA_W,
    parameter int ADDR_W      = RF_ADDR_W,
    parameter int HI_REG      = RF_HI_REG,
    parameter bit R0_WRITABLE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_rd,
    input  logic [DATA_W-1:0] md_lo,
    input  logic [DATA_W-1:0] md_hi,
    output logic              md_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic [15:0]       stall_cnt
);

    sched_state_e      state_q, state_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [DATA_W-1:0] md_hi_q, md_hi_d;
    logic [2:0]        req_s, gnt_s;
    logic              acc_s;
    logic [ADDR_W-1:0] acc_rd_s;
    logic [DATA_W-1:0] acc_data_s;

    function automatic logic slot_writes(input logic [ADDR_W-1:0] rd);
        return R0_WRITABLE || (rd != {ADDR_W{1'b0}});
    endfunction

    assign req_s = {md_valid, mem_valid, alu_valid};

    rr_arbiter3 u_arb (
        .clk   (clk),
        .reset (reset),
        .en_i  (state_q == ST_IDLE),
        .req_i (req_s),
        .gnt_o (gnt_s)
    );

    assign alu_ready = gnt_s[REQ_ALU];
    assign mem_ready = gnt_s[REQ_MEM];
    assign md_ready  = gnt_s[REQ_MD];

    // Select the payload for next cycle's write slot and advance the state.
    always_comb begin
        state_d    = state_q;
        md_hi_d    = md_hi_q;
        acc_s      = 1'b0;
        acc_rd_s   = rf_waddr_q;
        acc_data_s = rf_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_s[REQ_ALU]) begin
                    acc_s      = 1'b1;
                    acc_rd_s   = alu_rd;
                    acc_data_s = alu_data;
                end else if (gnt_s[REQ_MEM]) begin
                    acc_s      = 1'b1;
                    acc_rd_s   = mem_rd;
                    acc_data_s = mem_data;
                end else if (gnt_s[REQ_MD]) begin
                    acc_s      = 1'b1;
                    acc_rd_s   = md_rd;
                    acc_data_s = md_lo;
                    md_hi_d    = md_hi;
                    state_d    = ST_MD_HI;
                end else begin
                    acc_s      = 1'b0;
                end
            end
            ST_MD_HI: begin
                acc_s      = 1'b1;
                acc_rd_s   = ADDR_W'(HI_REG);
                acc_data_s = md_hi_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A suppressed R0 slot leaves address/data at their previous values.
        rf_we_d = acc_s && slot_writes(acc_rd_s);
        if (rf_we_d) begin
            rf_waddr_d = acc_rd_s;
            rf_wdata_d = acc_data_s;
        end else begin
            rf_waddr_d = rf_waddr_q;
            rf_wdata_d = rf_wdata_q;
        end
    end

    // State and registered write-port outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= {ADDR_W{1'b0}};
            rf_wdata_q <= {DATA_W{1'b0}};
            md_hi_q    <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            md_hi_q    <= md_hi_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = (state_q == ST_MD_HI);

`ifdef RF_SCHED_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where some valid requester went unserved, saturating.
    always_comb begin
        if ((|(req_s & ~gnt_s)) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Statistic register, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
